fifo_write_arbiter: RTL and testbench

// - Round-robin arbiter sharing the write port of asynchronous_fifo among
//   num_requesters sources, all in the trans_clk domain.
// - Grants one requester a burst of up to max_burst beats, then rotates.
// - Drives write_enable/trans_data and back-pressures requesters on fifo_full.

---
 rtl/fifo_write_arbiter_if.sv | 38 +++
 rtl/fifo_write_arbiter.sv | 110 +++++++++++
 tb/tb_fifo_write_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_write_arbiter_if.sv
// Write-port bundle between the requesters/FIFO side and fifo_write_arbiter.
// The beat_count field exists only when FIFO_WR_ARB_STATS_EN is defined.
interface fifo_write_arbiter_if #(
  parameter int num_requesters  = 4,
  parameter int data_bus_length = 8
);
  localparam int GW = $clog2(num_requesters);

  logic [num_requesters-1:0]                 req_valid;
  logic [num_requesters*data_bus_length-1:0] req_data;
  logic [num_requesters-1:0]                 req_ready;
  logic                                      fifo_full;
  logic                                      write_enable;
  logic [data_bus_length-1:0]                trans_data;
  logic [GW-1:0]                             grant_id;
  logic                                      busy;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [num_requesters*16-1:0]              beat_count;

  modport master (
    input  req_valid, req_data, fifo_full,
    output req_ready, write_enable, trans_data, grant_id, busy, beat_count
  );
  modport slave (
    output req_valid, req_data, fifo_full,
    input  req_ready, write_enable, trans_data, grant_id, busy, beat_count
  );
`else
  modport master (
    input  req_valid, req_data, fifo_full,
    output req_ready, write_enable, trans_data, grant_id, busy
  );
  modport slave (
    output req_valid, req_data, fifo_full,
    input  req_ready, write_enable, trans_data, grant_id, busy
  );
`endif
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter for the FIFO write port. Optional per-requester
// beat statistics are enabled by defining FIFO_WR_ARB_STATS_EN.
module fifo_write_arbiter #(
  parameter int num_requesters  = 4,
  parameter int data_bus_length = 8,
  parameter int max_burst       = 4
) (
  input  logic                 trans_clk,
  input  logic                 trans_rst,
  fifo_write_arbiter_if.master bus
);
  localparam int GW = $clog2(num_requesters);
  localparam int CW = $clog2(max_burst + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state_q;
  logic [GW-1:0]   rr_ptr_q;
  logic [GW-1:0]   grant_id_q;
  logic [CW-1:0]   beat_cnt_q;

  logic            in_burst;
  logic            gnt_valid;
  logic            beat;
  logic            last_beat;
  logic            drained;
  logic [GW-1:0]   rr_ptr_d;
  logic [GW-1:0]   pick_idx;
  logic            pick_vld;
  logic [num_requesters-1:0] ready;

  assign in_burst  = (state_q == BURST);
  assign gnt_valid = bus.req_valid[grant_id_q];
  assign beat      = in_burst & gnt_valid & ~bus.fifo_full;
  assign last_beat = beat & (beat_cnt_q == CW'(max_burst - 1));
  assign drained   = in_burst & ~gnt_valid & ~bus.fifo_full;
  assign rr_ptr_d  = (grant_id_q == GW'(num_requesters - 1)) ? '0 : grant_id_q + GW'(1);

  // Scan downward so the requester closest to rr_ptr (smallest offset) wins.
  always_comb begin
    int idx;
    idx      = 0;
    pick_idx = '0;
    pick_vld = 1'b0;
    for (int k = num_requesters - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr_q) + k) % num_requesters;
      if (bus.req_valid[idx]) begin
        pick_vld = 1'b1;
        pick_idx = GW'(idx);
      end
    end
  end

  always_comb begin
    ready = '0;
    if (in_burst) ready[grant_id_q] = ~bus.fifo_full;
  end

  assign bus.req_ready    = ready;
  assign bus.write_enable = beat;
  assign bus.trans_data   = in_burst ? bus.req_data[grant_id_q*data_bus_length +: data_bus_length]
                                     : '0;
  assign bus.grant_id     = grant_id_q;
  assign bus.busy         = in_burst;

  always_ff @(posedge trans_clk or negedge trans_rst) begin
    if (!trans_rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            grant_id_q <= pick_idx;
            beat_cnt_q <= '0;
            state_q    <= BURST;
          end
        end
        BURST: begin
          if (beat) beat_cnt_q <= beat_cnt_q + CW'(1);
          // A full FIFO holds the grant indefinitely, even if valid drops.
          if (last_beat || drained) begin
            state_q  <= IDLE;
            rr_ptr_q <= rr_ptr_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0] beat_count_q [num_requesters];

  always_ff @(posedge trans_clk or negedge trans_rst) begin
    if (!trans_rst) begin
      for (int i = 0; i < num_requesters; i++) beat_count_q[i] <= '0;
    end else if (beat && beat_count_q[grant_id_q] != 16'hFFFF) begin
      beat_count_q[grant_id_q] <= beat_count_q[grant_id_q] + 16'd1;
    end
  end

  for (genvar g = 0; g < num_requesters; g++) begin : g_stats
    assign bus.beat_count[g*16 +: 16] = beat_count_q[g];
  end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: directed vector table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_fifo_write_arbiter;
  localparam int N  = 4;
  localparam int D  = 8;
  localparam int MB = 4;

  logic trans_clk = 1'b0;
  logic trans_rst = 1'b1;
  always #5 trans_clk = ~trans_clk;

  fifo_write_arbiter_if #(.num_requesters(N), .data_bus_length(D)) bus();

  fifo_write_arbiter #(.num_requesters(N), .data_bus_length(D), .max_burst(MB)) dut (
    .trans_clk (trans_clk),
    .trans_rst (trans_rst),
    .bus       (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_const_data();
    for (int i = 0; i < N; i++) bus.req_data[i*D +: D] = 8'hA0 + 8'(i);
  endtask

  task automatic do_reset();
    @(negedge trans_clk);
    bus.req_valid = '0;
    bus.fifo_full = 1'b0;
    trans_rst     = 1'b0;
    @(negedge trans_clk);
    trans_rst     = 1'b1;
  endtask

  typedef struct {
    logic [N-1:0] valid;
    logic         full;
    logic         we;
    logic [N-1:0] rdy;
    int           g;
    logic         busy;
  } vec_t;

  vec_t tbl[20];

  // Reference model state: owner of the write port, beats taken, next start.
  int        m_busy, m_grant, m_beats, m_rr;
  int        stat_m[N];
  logic [D-1:0] q[N][$];

  task automatic model_reset();
    m_busy = 0; m_grant = 0; m_beats = 0; m_rr = 0;
    for (int i = 0; i < N; i++) begin
      stat_m[i] = 0;
      q[i].delete();
    end
  endtask

  task automatic run_beats(input int idx, input int n);
    int cnt, cyc;
    cnt = 0; cyc = 0;
    while (cnt < n && cyc < 2*n + 20) begin
      @(negedge trans_clk);
      bus.req_valid = N'(1) << idx;
      #1;
      if (bus.write_enable) cnt++;
      cyc++;
    end
    if (cnt < n) chk("run_beats_timeout", 64'(cnt), 64'(n));
    @(negedge trans_clk);
    bus.req_valid = '0;
    @(negedge trans_clk);
  endtask

  initial begin
    logic [N-1:0] v;
    logic         full, act, beat;
    logic [D-1:0] exp_data;
    logic [N-1:0] exp_rdy;
    int           gseq[$];
    int           idle_cnt, cyc, pick;

    tbl[0]  = '{4'b0001, 1'b0, 1'b0, 4'b0000, 0, 1'b0};
    tbl[1]  = '{4'b0001, 1'b0, 1'b1, 4'b0001, 0, 1'b1};
    tbl[2]  = '{4'b0001, 1'b0, 1'b1, 4'b0001, 0, 1'b1};
    tbl[3]  = '{4'b0001, 1'b1, 1'b0, 4'b0000, 0, 1'b1};
    tbl[4]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 0, 1'b1};
    tbl[5]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 0, 1'b1};
    tbl[6]  = '{4'b0001, 1'b1, 1'b0, 4'b0000, 0, 1'b1};
    tbl[7]  = '{4'b0001, 1'b1, 1'b0, 4'b0000, 0, 1'b1};
    tbl[8]  = '{4'b0001, 1'b0, 1'b1, 4'b0001, 0, 1'b1};
    tbl[9]  = '{4'b0001, 1'b0, 1'b1, 4'b0001, 0, 1'b1};
    tbl[10] = '{4'b0001, 1'b0, 1'b0, 4'b0000, 0, 1'b0};
    tbl[11] = '{4'b0001, 1'b0, 1'b1, 4'b0001, 0, 1'b1};
    tbl[12] = '{4'b0001, 1'b0, 1'b1, 4'b0001, 0, 1'b1};
    tbl[13] = '{4'b0000, 1'b0, 1'b0, 4'b0001, 0, 1'b1};
    tbl[14] = '{4'b0100, 1'b0, 1'b0, 4'b0000, 0, 1'b0};
    tbl[15] = '{4'b0100, 1'b0, 1'b1, 4'b0100, 2, 1'b1};
    tbl[16] = '{4'b0100, 1'b0, 1'b1, 4'b0100, 2, 1'b1};
    tbl[17] = '{4'b0000, 1'b0, 1'b0, 4'b0100, 2, 1'b1};
    tbl[18] = '{4'b1001, 1'b0, 1'b0, 4'b0000, 2, 1'b0};
    tbl[19] = '{4'b1001, 1'b0, 1'b1, 4'b1000, 3, 1'b1};

    // Reset state, with every requester asking so a stuck output would show.
    bus.req_valid = '1;
    bus.fifo_full = 1'b0;
    set_const_data();
    #2 trans_rst = 1'b0;
    #20;
    chk("rst_we",    64'(bus.write_enable), 64'(0));
    chk("rst_ready", 64'(bus.req_ready),    64'(0));
    chk("rst_busy",  64'(bus.busy),         64'(0));
    chk("rst_grant", 64'(bus.grant_id),     64'(0));
    chk("rst_data",  64'(bus.trans_data),   64'(0));
`ifdef FIFO_WR_ARB_STATS_EN
    chk("rst_stats", 64'(bus.beat_count),   64'(0));
`endif
    @(negedge trans_clk);
    bus.req_valid = '0;
    trans_rst     = 1'b1;

    // Directed table: single requester bursts, FIFO stall, drain, rotation.
    for (int i = 0; i < 20; i++) begin
      @(negedge trans_clk);
      bus.req_valid = tbl[i].valid;
      bus.fifo_full = tbl[i].full;
      #1;
      exp_data = tbl[i].busy ? (8'hA0 + 8'(tbl[i].g)) : 8'h00;
      chk($sformatf("vec%0d_we", i),    64'(bus.write_enable), 64'(tbl[i].we));
      chk($sformatf("vec%0d_ready", i), 64'(bus.req_ready),    64'(tbl[i].rdy));
      chk($sformatf("vec%0d_grant", i), 64'(bus.grant_id),     64'(tbl[i].g));
      chk($sformatf("vec%0d_busy", i),  64'(bus.busy),         64'(tbl[i].busy));
      chk($sformatf("vec%0d_data", i),  64'(bus.trans_data),   64'(exp_data));
    end

    // All requesting: grants rotate 0,1,2,3,0 with 4 beats and 1 idle each.
    do_reset();
    idle_cnt = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge trans_clk);
      bus.req_valid = '1;
      #1;
      if (bus.write_enable) gseq.push_back(int'(bus.grant_id));
      if (!bus.busy) idle_cnt++;
    end
    chk("rr_beats", 64'(gseq.size()), 64'(20));
    chk("rr_idles", 64'(idle_cnt),    64'(5));
    for (int k = 0; k < gseq.size() && k < 20; k++)
      chk($sformatf("rr_seq%0d", k), 64'(gseq[k]), 64'((k / 4) % N));

    // Asynchronous reset in the middle of requester 2's burst.
    cyc = 0;
    while (!(bus.busy && bus.grant_id == 2) && cyc < 40) begin
      @(negedge trans_clk);
      #1;
      cyc++;
    end
    chk("mid_rst_reach", 64'(bus.busy && bus.grant_id == 2), 64'(1));
    #2 trans_rst = 1'b0;
    #1;
    chk("mid_rst_we",    64'(bus.write_enable), 64'(0));
    chk("mid_rst_ready", 64'(bus.req_ready),    64'(0));
    chk("mid_rst_busy",  64'(bus.busy),         64'(0));
    chk("mid_rst_grant", 64'(bus.grant_id),     64'(0));
    chk("mid_rst_data",  64'(bus.trans_data),   64'(0));
    @(negedge trans_clk);
    trans_rst = 1'b1;
    @(negedge trans_clk);
    #1;
    chk("post_rst_busy", 64'(bus.busy),     64'(1));
    chk("post_rst_grant", 64'(bus.grant_id), 64'(0));

    // Randomized traffic against the queue model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge trans_clk);
      for (int i = 0; i < N; i++) begin
        if (q[i].size() < 3 && $urandom_range(3) == 0) q[i].push_back(D'($urandom));
        act  = ($urandom_range(9) != 0);
        v[i] = (q[i].size() > 0) && act;
        bus.req_data[i*D +: D] = (q[i].size() > 0) ? q[i][0] : '0;
      end
      full = ($urandom_range(6) == 0);
      bus.req_valid = v;
      bus.fifo_full = full;
      #1;
      beat     = m_busy != 0 && v[m_grant] && !full;
      exp_rdy  = (m_busy != 0 && !full) ? (N'(1) << m_grant) : '0;
      exp_data = (m_busy != 0 && q[m_grant].size() > 0) ? q[m_grant][0] : '0;
      chk("rnd_we",    64'(bus.write_enable), 64'(beat));
      chk("rnd_ready", 64'(bus.req_ready),    64'(exp_rdy));
      chk("rnd_grant", 64'(bus.grant_id),     64'(m_grant));
      chk("rnd_busy",  64'(bus.busy),         64'(m_busy != 0));
      chk("rnd_data",  64'(bus.trans_data),   64'(exp_data));
      if (m_busy == 0) begin
        pick = -1;
        for (int k = 0; k < N; k++)
          if (pick < 0 && v[(m_rr + k) % N]) pick = (m_rr + k) % N;
        if (pick >= 0) begin
          m_grant = pick; m_busy = 1; m_beats = 0;
        end
      end else begin
        if (beat) begin
          m_beats++;
          void'(q[m_grant].pop_front());
          if (stat_m[m_grant] < 16'hFFFF) stat_m[m_grant]++;
        end
        if ((beat && m_beats == MB) || (!v[m_grant] && !full)) begin
          m_busy = 0;
          m_rr   = (m_grant + 1) % N;
        end
      end
    end
`ifdef FIFO_WR_ARB_STATS_EN
    for (int i = 0; i < N; i++)
      chk($sformatf("rnd_stat%0d", i), 64'(bus.beat_count[i*16 +: 16]), 64'(stat_m[i]));

    // Statistics: exact counts, then saturation.
    do_reset();
    set_const_data();
    run_beats(1, 10);
    run_beats(3, 3);
    chk("stat_f0", 64'(bus.beat_count[0*16 +: 16]), 64'(0));
    chk("stat_f1", 64'(bus.beat_count[1*16 +: 16]), 64'(10));
    chk("stat_f2", 64'(bus.beat_count[2*16 +: 16]), 64'(0));
    chk("stat_f3", 64'(bus.beat_count[3*16 +: 16]), 64'(3));
    run_beats(0, 70000);
    chk("stat_sat", 64'(bus.beat_count[0*16 +: 16]), 64'(16'hFFFF));
    chk("stat_f1_kept", 64'(bus.beat_count[1*16 +: 16]), 64'(10));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
